// File: rtl/riscv_alu_seq.sv
// RV32I-style integer ALU with valid/ready handshakes and a registered result.
// Shifts iterate SHIFT_STEP bits per cycle; everything else completes in one cycle.
module riscv_alu_seq #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int SHAMT_W    = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [3:0]      i_op,
  input  logic            i_use_imm,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_busy
);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                         OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_OR = 4'd8, OP_AND = 4'd9;
  localparam logic [SHAMT_W:0] STEP = (SHAMT_W+1)'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              r_state;
  logic [3:0]          r_op;
  logic [XLEN-1:0]     r_shf;
  logic [SHAMT_W-1:0]  r_rem;
  logic [XLEN-1:0]     r_result;
  logic                r_zero;
  logic                r_out_valid;
  logic                r_busy;

  logic [XLEN-1:0]     w_op2;
  logic [SHAMT_W-1:0]  w_shamt;
  logic                w_is_shift;
  logic                w_accept;
  logic [XLEN-1:0]     w_res;
  logic [SHAMT_W:0]    w_k;
  logic [SHAMT_W-1:0]  w_rem_nxt;
  logic [XLEN-1:0]     w_shifted;

  assign w_op2      = i_use_imm ? i_imm : i_b;
  assign w_shamt    = w_op2[SHAMT_W-1:0];
  assign w_is_shift = (i_op == OP_SLL) || (i_op == OP_SRL) || (i_op == OP_SRA);
  assign o_in_ready = i_rst_n && ((r_state == IDLE) || ((r_state == DONE) && i_out_ready));
  assign w_accept   = i_in_valid && o_in_ready;

  // Single-cycle result; a zero-amount shift is just the operand passed through.
  always_comb begin
    w_res = '0;
    case (i_op)
      OP_ADD:  w_res = i_a + w_op2;
      OP_SUB:  w_res = i_a - w_op2;
      OP_SLT:  w_res = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(w_op2)};
      OP_SLTU: w_res = {{(XLEN-1){1'b0}}, i_a < w_op2};
      OP_XOR:  w_res = i_a ^ w_op2;
      OP_OR:   w_res = i_a | w_op2;
      OP_AND:  w_res = i_a & w_op2;
      OP_SLL, OP_SRL, OP_SRA: w_res = i_a;
      default: w_res = '0;
    endcase
  end

  // remaining is always < XLEN, so it never exceeds a full-width step
  assign w_k       = ({1'b0, r_rem} < STEP) ? {1'b0, r_rem} : STEP;
  assign w_rem_nxt = r_rem - w_k[SHAMT_W-1:0];

  always_comb begin
    w_shifted = r_shf;
    case (r_op)
      OP_SLL:  w_shifted = r_shf << w_k;
      OP_SRL:  w_shifted = r_shf >> w_k;
      OP_SRA:  w_shifted = $signed(r_shf) >>> w_k;
      default: w_shifted = r_shf;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_shf       <= '0;
      r_rem       <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        SHIFT: begin
          r_shf <= w_shifted;
          r_rem <= w_rem_nxt;
          if (w_rem_nxt == '0) begin
            r_result    <= w_shifted;
            r_zero      <= (w_shifted == '0);
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          if (r_state == DONE && i_out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
          // An accept in DONE overrides the return to IDLE above.
          if (w_accept) begin
            if (w_is_shift && w_shamt != '0) begin
              r_op        <= i_op;
              r_shf       <= i_a;
              r_rem       <= w_shamt;
              r_state     <= SHIFT;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              r_result    <= w_res;
              r_zero      <= (w_res == '0);
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_zero      = r_zero;
  assign o_busy      = r_busy;

endmodule
